sha512_padder: RTL and testbench

//  Assembles 64-byte cache lines returned by sha512_requestor into 1024-bit SHA-512 blocks (block[2]) for sha512.

---
 rtl/sha512_pkg.sv | 26 ++
 rtl/sha512_pad_line.sv | 52 +++++
 rtl/sha512_padder.sv | 154 +++++++++++++++
 tb/tb_sha512_padder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 message padding path.
package sha512_pkg;

  localparam int SHA512_BLOCK_BYTES = 128;
  localparam int SHA512_LEN_OFFSET  = 112;
  localparam int SHA512_LINE_BYTES  = 64;

  typedef logic [511:0] t_block;

  typedef enum logic [1:0] {
    FILL_LO,
    FILL_HI,
    EMIT,
    EXTRA
  } t_pad_state;

  // Bit i set when byte i of a 64-byte line lies below nbytes.
  function automatic logic [63:0] byte_mask(input logic [7:0] nbytes);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) begin
      m[i] = (nbytes > 8'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/sha512_pad_line.sv
// Builds one 64-byte half of a SHA-512 block: keeps message bytes below n,
// places the 0x80 marker at byte n and the big-endian length in bytes 112..127.
module sha512_pad_line
  import sha512_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic [511:0]     data,
  input  logic             hi,
  input  logic [7:0]       n,
  input  logic [LEN_W-1:0] len,
  input  logic             marker_en,
  input  logic             len_en,
  output logic [511:0]     line
);

  localparam int LEN_BYTE0 = SHA512_LEN_OFFSET - SHA512_LINE_BYTES;

  logic [7:0]   local_n;
  logic [63:0]  keep;
  logic [127:0] len128;

  // Number of message bytes that fall inside this half.
  always_comb begin
    local_n = 8'd0;
    if (hi) begin
      if (n > 8'd64) local_n = n - 8'd64;
    end else begin
      local_n = (n > 8'd64) ? 8'd64 : n;
    end
  end

  assign keep   = byte_mask(local_n);
  assign len128 = 128'(len);

  for (genvar gi = 0; gi < SHA512_LINE_BYTES; gi++) begin : g_byte
    logic [7:0] pos;
    logic       marker_hit;
    assign pos        = {1'b0, hi, 6'(gi)};
    assign marker_hit = marker_en && (n == pos);
    if (gi >= LEN_BYTE0) begin : g_len
      assign line[8*gi +: 8] = keep[gi]        ? data[8*gi +: 8] :
                               marker_hit      ? 8'h80 :
                               (len_en && hi)  ? len128[8*(SHA512_LINE_BYTES-1-gi) +: 8] :
                                                 8'h00;
    end else begin : g_plain
      assign line[8*gi +: 8] = keep[gi]   ? data[8*gi +: 8] :
                               marker_hit ? 8'h80 : 8'h00;
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// Packs 64-byte response lines into 1024-bit SHA-512 blocks and appends
// the FIPS 180-4 padding, adding a trailing block when the length does not fit.
module sha512_padder
  import sha512_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         line_valid,
  input  logic [511:0] line_data,
  input  logic         line_last,
  input  logic [6:0]   line_bytes,
  output logic         line_ready,
  output t_block       block [2],
  output logic         block_valid,
  output logic         block_last,
  input  logic         ready
);

  t_pad_state       state_reg;
  logic [LEN_W-1:0] len_reg;
  logic             extra_reg;
  logic             marker_reg;
  logic             final_reg;
  t_block           asm_reg [2];

  logic             accept;
  logic             in_extra;
  logic [6:0]       bytes_eff;
  logic [7:0]       n_cur;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] pad_len;
  logic [7:0]       pad_n;
  logic             pad_marker;
  logic             pad_len_en;
  t_block           pad_data [2];
  t_block           pad_out  [2];

  assign accept   = line_valid && line_ready;
  assign in_extra = (state_reg == EXTRA);

  always_comb begin
    bytes_eff = 7'd64;
    if (line_last && (line_bytes < 7'd64)) bytes_eff = line_bytes;
  end

  assign n_cur    = ((state_reg == FILL_HI) ? 8'd64 : 8'd0) + {1'b0, bytes_eff};
  assign len_next = len_reg + LEN_W'({bytes_eff, 3'b000});

  // The extra block reuses the same pad logic with no message bytes (n = 0).
  assign pad_len    = in_extra ? len_reg : len_next;
  assign pad_n      = in_extra ? 8'd0 : n_cur;
  assign pad_marker = in_extra ? marker_reg : (line_last && (n_cur != 8'd128));
  assign pad_len_en = in_extra || (line_last && (n_cur <= 8'd111));

  always_comb begin
    pad_data[0] = in_extra ? '0 : line_data;
    pad_data[1] = (state_reg == FILL_HI) ? line_data : '0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    sha512_pad_line #(
      .LEN_W(LEN_W)
    ) u_pad (
      .data      (pad_data[gi]),
      .hi        (gi == 1),
      .n         (pad_n),
      .len       (pad_len),
      .marker_en (pad_marker),
      .len_en    (pad_len_en),
      .line      (pad_out[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FILL_LO;
      line_ready  <= 1'b0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      block[0]    <= '0;
      block[1]    <= '0;
      asm_reg[0]  <= '0;
      asm_reg[1]  <= '0;
      len_reg     <= '0;
      extra_reg   <= 1'b0;
      marker_reg  <= 1'b0;
      final_reg   <= 1'b0;
    end else begin
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      case (state_reg)
        FILL_LO: begin
          line_ready <= 1'b1;
          if (accept) begin
            asm_reg[0] <= pad_out[0];
            len_reg    <= len_next;
            if (line_last) begin
              // At most 64 bytes here, so marker and length always fit.
              asm_reg[1] <= pad_out[1];
              final_reg  <= 1'b1;
              extra_reg  <= 1'b0;
              marker_reg <= 1'b0;
              line_ready <= 1'b0;
              state_reg  <= EMIT;
            end else begin
              state_reg <= FILL_HI;
            end
          end
        end
        FILL_HI: begin
          if (accept) begin
            asm_reg[1] <= pad_out[1];
            len_reg    <= len_next;
            final_reg  <= line_last && (n_cur <= 8'd111);
            extra_reg  <= line_last && (n_cur >= 8'd112);
            marker_reg <= line_last && (n_cur == 8'd128);
            line_ready <= 1'b0;
            state_reg  <= EMIT;
          end
        end
        EMIT: begin
          if (ready) begin
            block_valid <= 1'b1;
            block_last  <= final_reg;
            block[0]    <= asm_reg[0];
            block[1]    <= asm_reg[1];
            if (final_reg) begin
              len_reg   <= '0;
              extra_reg <= 1'b0;
            end
            if (extra_reg) begin
              state_reg <= EXTRA;
            end else begin
              line_ready <= 1'b1;
              state_reg  <= FILL_LO;
            end
          end
        end
        EXTRA: begin
          asm_reg[0] <= pad_out[0];
          asm_reg[1] <= pad_out[1];
          extra_reg  <= 1'b0;
          marker_reg <= 1'b0;
          final_reg  <= 1'b1;
          state_reg  <= EMIT;
        end
        default: state_reg <= FILL_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_padder.sv
// Scoreboard bench for sha512_padder: a byte-queue padding model feeds
// expected blocks, an independent monitor compares every block_valid pulse.
module tb_sha512_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         line_valid;
  logic [511:0] line_data;
  logic         line_last;
  logic [6:0]   line_bytes;
  logic         line_ready;
  logic [511:0] blk [2];
  logic         block_valid;
  logic         block_last;
  logic         ready = 1'b0;

  always #5 clk = ~clk;

  sha512_padder dut (
    .clk         (clk),
    .reset       (reset),
    .line_valid  (line_valid),
    .line_data   (line_data),
    .line_last   (line_last),
    .line_bytes  (line_bytes),
    .line_ready  (line_ready),
    .block       (blk),
    .block_valid (block_valid),
    .block_last  (block_last),
    .ready       (ready)
  );

  typedef struct {
    logic [511:0] b0;
    logic [511:0] b1;
    logic         last;
  } exp_t;

  exp_t         exp_q [$];
  logic [511:0] got_b0 [$];
  logic [511:0] got_b1 [$];
  logic         got_last [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           ready_mode = 1;  // 0 random, 1 high, 2 low
  logic         ready_prev = 1'b0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] got_blk(input int idx, input int half);
    if (idx >= got_b0.size()) return 'x;
    return (half == 0) ? got_b0[idx] : got_b1[idx];
  endfunction

  function automatic logic got_lst(input int idx);
    if (idx >= got_last.size()) return 1'bx;
    return got_last[idx];
  endfunction

  // Reference: append 0x80, zero-fill to 112 mod 128, append 128-bit bit length.
  task automatic model_push(input byte unsigned msg [$]);
    byte unsigned pad [$];
    logic [127:0] bits;
    exp_t         e;
    int           nblk;
    pad = msg;
    pad.push_back(8'h80);
    while ((pad.size() % 128) != 112) pad.push_back(8'h00);
    bits = 128'(msg.size()) << 3;
    for (int k = 15; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nblk = pad.size() / 128;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) begin
        e.b0[8*i +: 8] = pad[b*128 + i];
        e.b1[8*i +: 8] = pad[b*128 + 64 + i];
      end
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = ($urandom_range(0, 3) != 0);
        1:       ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && block_valid) begin
        check("valid_after_ready", 512'(ready_prev), 512'(1));
        got_b0.push_back(blk[0]);
        got_b1.push_back(blk[1]);
        got_last.push_back(block_last);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_block: got block_valid=1 expected no block, block0=%0h", blk[0]);
        end else begin
          e = exp_q.pop_front();
          check("block0", blk[0], e.b0);
          check("block1", blk[1], e.b1);
          check("block_last", 512'(block_last), 512'(e.last));
        end
      end
      ready_prev = ready;
    end
  end

  task automatic send_line(input logic [511:0] d, input logic last, input logic [6:0] nb);
    int waited = 0;
    line_valid = 1'b1;
    line_data  = d;
    line_last  = last;
    line_bytes = nb;
    do begin
      @(negedge clk);
      waited++;
    end while (!line_ready && waited < 2000);
    if (!line_ready) begin
      n_checks++;
      $display("FAIL line_accept: line_ready=0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1;
    line_valid = 1'b0;
    line_last  = 1'b0;
    line_bytes = 7'($urandom_range(0, 127));
    line_data  = rand512();
  endtask

  // Sends up to max_lines lines of msg; expectations are queued only for complete messages.
  task automatic send_bytes(input byte unsigned msg [$], input int max_lines, input bit gaps);
    int           nlines;
    int           rem;
    logic [511:0] d;
    logic         last;
    logic [6:0]   nb;
    nlines = (msg.size() == 0) ? 1 : (msg.size() + 63) / 64;
    if (max_lines >= nlines) model_push(msg);
    for (int ln = 0; ln < nlines && ln < max_lines; ln++) begin
      d    = rand512();
      last = (ln == nlines - 1);
      rem  = msg.size() - 64 * ln;
      if (rem > 64) rem = 64;
      for (int b = 0; b < rem; b++) d[8*b +: 8] = msg[64*ln + b];
      if (!last) nb = 7'($urandom_range(0, 127));
      else if (rem == 64 && $urandom_range(0, 1) == 1) nb = 7'($urandom_range(64, 127));
      else nb = 7'(rem);
      send_line(d, last, nb);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_random(input int len, input int max_lines, input bit gaps);
    byte unsigned msg [$];
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_bytes(msg, max_lines, gaps);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s_drain: %0d blocks outstanding, expected 0", name, exp_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic check_abc(input string name, input int idx);
    check({name, "_b0"}, got_blk(idx, 0), 512'h80636261);
    check({name, "_b1"}, got_blk(idx, 1), {16'h1800, 496'b0});
    check({name, "_last"}, 512'(got_lst(idx)), 512'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    byte unsigned msg [$];
    int idx;
    int bnd [21] = '{0, 1, 3, 55, 63, 64, 65, 111, 112, 113, 127, 128, 129,
                     191, 192, 239, 240, 241, 255, 256, 300};
    reset      = 1'b1;
    line_valid = 1'b0;
    line_data  = '0;
    line_last  = 1'b0;
    line_bytes = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_line_ready", 512'(line_ready), 512'(0));
    check("rst_block_valid", 512'(block_valid), 512'(0));
    check("rst_block_last", 512'(block_last), 512'(0));
    check("rst_block0", blk[0], 512'(0));
    check("rst_block1", blk[1], 512'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // "abc"
    idx = got_b0.size();
    msg = {8'h61, 8'h62, 8'h63};
    send_bytes(msg, 99, 1'b0);
    wait_drain("abc");
    check_abc("abc", idx);

    // empty message
    idx = got_b0.size();
    msg.delete();
    send_bytes(msg, 99, 1'b0);
    wait_drain("empty");
    check("empty_b0", got_blk(idx, 0), 512'h80);
    check("empty_b1", got_blk(idx, 1), 512'(0));
    check("empty_last", 512'(got_lst(idx)), 512'(1));

    // 112 bytes: marker fills block, length spills to an extra block
    idx = got_b0.size();
    send_random(112, 99, 1'b0);
    wait_drain("len112");
    check("len112_marker", 512'(got_blk(idx, 1)[511:384]), 512'(8'h80));
    check("len112_first_last", 512'(got_lst(idx)), 512'(0));
    check("len112_x_b0", got_blk(idx + 1, 0), 512'(0));
    check("len112_x_b1", got_blk(idx + 1, 1), {16'h8003, 496'b0});
    check("len112_x_last", 512'(got_lst(idx + 1)), 512'(1));

    // 128 bytes: marker moves into the extra block
    idx = got_b0.size();
    send_random(128, 99, 1'b0);
    wait_drain("len128");
    check("len128_first_last", 512'(got_lst(idx)), 512'(0));
    check("len128_x_b0", got_blk(idx + 1, 0), 512'h80);
    check("len128_x_b1", got_blk(idx + 1, 1), {16'h0004, 496'b0});
    check("len128_x_last", 512'(got_lst(idx + 1)), 512'(1));

    // backpressure in EMIT
    ready_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    msg = {8'h61, 8'h62, 8'h63};
    send_bytes(msg, 99, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_block_valid_low", 512'(block_valid), 512'(0));
      check("bp_line_ready_low", 512'(line_ready), 512'(0));
    end
    ready_mode = 1;
    @(negedge clk);
    check("bp_pulse_wait", 512'(block_valid), 512'(0));
    @(negedge clk);
    check("bp_pulse", 512'(block_valid), 512'(1));
    @(negedge clk);
    check("bp_pulse_end", 512'(block_valid), 512'(0));
    @(posedge clk);
    #1;
    wait_drain("bp");

    // reset in the middle of a 3-line message
    send_random(192, 1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_line_ready", 512'(line_ready), 512'(0));
    check("mid_rst_block_valid", 512'(block_valid), 512'(0));
    check("mid_rst_block0", blk[0], 512'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idx = got_b0.size();
    msg = {8'h61, 8'h62, 8'h63};
    send_bytes(msg, 99, 1'b0);
    wait_drain("post_rst_abc");
    check_abc("post_rst_abc", idx);

    // randomized lengths with random backpressure and line gaps
    ready_mode = 0;
    for (int m = 0; m < 40; m++) begin
      if ($urandom_range(0, 1) == 1) send_random(bnd[$urandom_range(0, 20)], 99, 1'b1);
      else send_random(int'($urandom_range(0, 320)), 99, 1'b1);
    end
    wait_drain("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
